// File: rtl/safe_pkg.sv
// Shared definitions for the safe controller family: key codes and lock states.
package safe_pkg;

  localparam logic [3:0] KEY_ENTER = 4'd10;
  localparam logic [3:0] KEY_STAR  = 4'd11;
  localparam logic [3:0] KEY_NONE  = 4'd13;

  typedef enum logic [1:0] {
    ENTRY    = 2'd0,
    UNLOCKED = 2'd1,
    PROG     = 2'd2,
    LOCKOUT  = 2'd3
  } safe_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/safe_timer.sv
// Loadable down-counter. done is high while the count sits at 1, i.e. during
// the last cycle of a window that started with the load, so a window of N
// cycles ends at the edge after done is seen. The count parks at 0.
module safe_timer #(
  parameter int TW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          done
);

  logic [TW-1:0] count;

  // Load wins over counting; stop at zero instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - TW'(1);
    end
  end

  assign done = (count == TW'(1));

endmodule

// File: rtl/safe_code_checker.sv
// Keypad code-entry controller: collects a fixed-length digit code, compares
// it against the stored code, unlocks for a timed window, enforces a timed
// lockout after repeated failures and allows reprogramming while unlocked.
module safe_code_checker
  import safe_pkg::*;
#(
  parameter int                      CODE_LEN       = 4,
  parameter int                      MAX_FAIL       = 3,
  parameter int                      UNLOCK_CYCLES  = 500,
  parameter int                      LOCKOUT_CYCLES = 1000,
  parameter logic [CODE_LEN*4-1:0]   DEFAULT_CODE   = 16'h1234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  output logic       unlocked,
  output logic       lockout,
  output logic       prog_mode,
  output logic       error_pulse,
  output logic [3:0] entry_count
);

  localparam int CW = CODE_LEN * 4;
  localparam int TW = $clog2(max_int(UNLOCK_CYCLES, LOCKOUT_CYCLES) + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);

  localparam logic [3:0]    CODE_LEN_C  = 4'(CODE_LEN);
  localparam logic [FW-1:0] FAIL_LAST   = FW'(MAX_FAIL - 1);
  localparam logic [TW-1:0] UNLOCK_LOAD = TW'(UNLOCK_CYCLES);
  localparam logic [TW-1:0] LOCK_LOAD   = TW'(LOCKOUT_CYCLES);

  safe_state_t   state_q, state_d;
  logic [CW-1:0] code_buf_q, code_buf_d;
  logic [CW-1:0] stored_q, stored_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [FW-1:0] fail_q, fail_d;
  logic          err_d;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_done;

  logic is_digit, is_hash, is_star, full_entry, code_match;

  assign is_digit   = (key_code <= 4'd9);
  assign is_hash    = (key_code == KEY_ENTER);
  assign is_star    = (key_code == KEY_STAR);
  assign full_entry = (cnt_q == CODE_LEN_C) && !ovf_q;
  assign code_match = full_entry && (code_buf_q == stored_q);

  // One timer serves both timed states; they never overlap.
  safe_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Next-state, buffer, fail counter and timer-load decisions.
  always_comb begin
    state_d    = state_q;
    code_buf_d = code_buf_q;
    stored_d   = stored_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    fail_d     = fail_q;
    err_d      = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;

    case (state_q)
      ENTRY: begin
        if (is_digit) begin
          if (cnt_q < CODE_LEN_C) begin
            code_buf_d = (code_buf_q << 4) | CW'(key_code);
            cnt_d      = cnt_q + 4'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (is_star) begin
          code_buf_d = '0;
          cnt_d      = '0;
          ovf_d      = 1'b0;
        end else if (is_hash && cnt_q != 4'd0) begin
          if (code_match) begin
            state_d = UNLOCKED;
            fail_d  = '0;
          end else begin
            err_d = 1'b1;
            if (fail_q == FAIL_LAST) begin
              state_d = LOCKOUT;
              fail_d  = '0;
            end else begin
              fail_d = fail_q + FW'(1);
            end
            // A rejected attempt that stays in ENTRY starts a fresh code.
            code_buf_d = '0;
            cnt_d      = '0;
            ovf_d      = 1'b0;
          end
        end
      end
      UNLOCKED: begin
        // Expiry has priority so the open window never exceeds its length.
        if (tmr_done || is_hash) begin
          state_d = ENTRY;
        end else if (is_star) begin
          state_d = PROG;
        end
      end
      PROG: begin
        if (is_digit) begin
          if (cnt_q < CODE_LEN_C) begin
            code_buf_d = (code_buf_q << 4) | CW'(key_code);
            cnt_d      = cnt_q + 4'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (is_star) begin
          state_d = ENTRY;
        end else if (is_hash && cnt_q != 4'd0) begin
          if (full_entry) begin
            stored_d = code_buf_q;
            state_d  = ENTRY;
          end else begin
            err_d      = 1'b1;
            code_buf_d = '0;
            cnt_d      = '0;
            ovf_d      = 1'b0;
          end
        end
      end
      LOCKOUT: begin
        if (tmr_done) begin
          state_d = ENTRY;
        end
      end
      default: state_d = ENTRY;
    endcase

    // Every state change starts from an empty buffer; timed states arm the timer.
    if (state_d != state_q) begin
      code_buf_d = '0;
      cnt_d      = '0;
      ovf_d      = 1'b0;
      if (state_d == UNLOCKED) begin
        tmr_load = 1'b1;
        tmr_val  = UNLOCK_LOAD;
      end else if (state_d == LOCKOUT) begin
        tmr_load = 1'b1;
        tmr_val  = LOCK_LOAD;
      end
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ENTRY;
      code_buf_q  <= '0;
      stored_q    <= DEFAULT_CODE;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      fail_q      <= '0;
      unlocked    <= 1'b0;
      lockout     <= 1'b0;
      prog_mode   <= 1'b0;
      error_pulse <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_buf_q  <= code_buf_d;
      stored_q    <= stored_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      fail_q      <= fail_d;
      unlocked    <= (state_d == UNLOCKED);
      lockout     <= (state_d == LOCKOUT);
      prog_mode   <= (state_d == PROG);
      error_pulse <= err_d;
    end
  end

  assign entry_count = cnt_q;

endmodule

// File: tb/tb_safe_code_checker.sv
// Directed bench for safe_code_checker with short timer windows.
module tb_safe_code_checker;
  import safe_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] key_code;
  logic       unlocked;
  logic       lockout;
  logic       prog_mode;
  logic       error_pulse;
  logic [3:0] entry_count;

  int n_chk  = 0;
  int n_pass = 0;

  safe_code_checker #(
    .CODE_LEN       (4),
    .MAX_FAIL       (3),
    .UNLOCK_CYCLES  (20),
    .LOCKOUT_CYCLES (30),
    .DEFAULT_CODE   (16'h1234)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_code    (key_code),
    .unlocked    (unlocked),
    .lockout     (lockout),
    .prog_mode   (prog_mode),
    .error_pulse (error_pulse),
    .entry_count (entry_count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checker
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // Driver tasks: each call ends 1ns after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_code = k;
    @(posedge clk);
    #1;
    key_code = KEY_NONE;
  endtask

  task automatic enter4(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) press(code[i*4 +: 4]);
  endtask

  task automatic unlocked_len(output int n);
    n = 0;
    while (unlocked && n < 300) begin
      n++;
      idle(1);
    end
  endtask

  task automatic wrong_rounds();
    for (int r = 0; r < 3; r++) begin
      enter4(16'h1235);
      press(KEY_ENTER);
      chk("wrong_err", 32'(error_pulse), 1);
      chk("wrong_lock", 32'(lockout), (r == 2) ? 1 : 0);
      if (r < 2) begin
        idle(1);
        chk("wrong_err_1cyc", 32'(error_pulse), 0);
      end
    end
  endtask

  int n;
  int n_l;

  initial begin
    rst      = 1'b1;
    key_code = KEY_NONE;
    idle(2);
    chk("rst_unlocked", 32'(unlocked), 0);
    chk("rst_lockout", 32'(lockout), 0);
    chk("rst_prog", 32'(prog_mode), 0);
    chk("rst_err", 32'(error_pulse), 0);
    chk("rst_count", 32'(entry_count), 0);
    rst = 1'b0;
    idle(2);

    // Correct entry
    for (int d = 1; d <= 4; d++) begin
      press(4'(d));
      chk("entry_count_step", 32'(entry_count), 32'(d));
    end
    press(KEY_ENTER);
    chk("ok_unlocked", 32'(unlocked), 1);
    chk("ok_count0", 32'(entry_count), 0);
    chk("ok_no_err", 32'(error_pulse), 0);
    unlocked_len(n);
    chk("unlock_len", 32'(n), 20);
    idle(1);

    // Wrong code three times, then lockout
    wrong_rounds();
    n_l = 1;
    idle(1);
    chk("lock_err_1cyc", 32'(error_pulse), 0);
    if (lockout) n_l++;
    for (int i = 0; i < 5; i++) begin
      press((i < 4) ? 4'(i + 1) : KEY_ENTER);
      if (lockout) n_l++;
    end
    chk("lock_ignores_keys", 32'(unlocked), 0);
    chk("lock_count0", 32'(entry_count), 0);
    while (lockout && n_l < 300) begin
      idle(1);
      if (lockout) n_l++;
    end
    chk("lockout_len", 32'(n_l), 30);
    enter4(16'h1234);
    press(KEY_ENTER);
    chk("after_lock_unlock", 32'(unlocked), 1);
    press(4'd5);
    chk("unlocked_ignores_digit", 32'(entry_count), 0);
    press(KEY_ENTER);
    chk("relock", 32'(unlocked), 0);

    // Clear and overflow
    press(4'd1);
    press(4'd2);
    press(KEY_STAR);
    chk("star_clears", 32'(entry_count), 0);
    enter4(16'h1234);
    press(KEY_ENTER);
    chk("star_then_ok", 32'(unlocked), 1);
    chk("star_then_ok_err", 32'(error_pulse), 0);
    press(KEY_ENTER);
    enter4(16'h1234);
    press(4'd5);
    chk("ovf_count", 32'(entry_count), 4);
    press(KEY_ENTER);
    chk("ovf_err", 32'(error_pulse), 1);
    chk("ovf_no_unlock", 32'(unlocked), 0);
    press(4'd1);
    press(4'd12);
    press(4'd14);
    press(4'd15);
    chk("ignored_keys_count", 32'(entry_count), 1);
    chk("ignored_keys_state", 32'({unlocked, lockout, prog_mode, error_pulse}), 0);
    press(KEY_STAR);
    press(KEY_ENTER);
    chk("empty_hash_no_err", 32'(error_pulse), 0);

    // Programming
    enter4(16'h1234);
    press(KEY_ENTER);
    press(KEY_STAR);
    chk("prog_on", 32'(prog_mode), 1);
    chk("prog_not_unlocked", 32'(unlocked), 0);
    press(4'd9);
    press(4'd8);
    press(KEY_ENTER);
    chk("prog_short_err", 32'(error_pulse), 1);
    chk("prog_short_stay", 32'(prog_mode), 1);
    chk("prog_short_clear", 32'(entry_count), 0);
    enter4(16'h9876);
    press(KEY_ENTER);
    chk("prog_done", 32'(prog_mode), 0);
    chk("prog_locked", 32'(unlocked), 0);
    enter4(16'h1234);
    press(KEY_ENTER);
    chk("old_code_err", 32'(error_pulse), 1);
    chk("old_code_locked", 32'(unlocked), 0);
    enter4(16'h9876);
    press(KEY_ENTER);
    chk("new_code_unlock", 32'(unlocked), 1);
    press(KEY_STAR);
    press(4'd1);
    press(4'd1);
    press(KEY_STAR);
    chk("prog_abort", 32'(prog_mode), 0);
    enter4(16'h9876);
    press(KEY_ENTER);
    chk("abort_keeps_code", 32'(unlocked), 1);
    press(KEY_ENTER);

    // Async reset mid-lockout restores the default code
    wrong_rounds();
    idle(3);
    rst = 1'b1;
    #1;
    chk("async_rst_lockout", 32'(lockout), 0);
    idle(1);
    rst = 1'b0;
    idle(1);
    enter4(16'h1234);
    press(KEY_ENTER);
    chk("rst_default_code", 32'(unlocked), 1);
    press(KEY_STAR);
    chk("prog_before_rst", 32'(prog_mode), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_prog", 32'(prog_mode), 0);
    idle(1);
    rst = 1'b0;
    idle(1);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
